latch_stim_checker: RTL and testbench
=====================================

// Module: latch_stim_checker
// PURPOSE
//   Synthesizable stimulus generator and self-checker for a single D latch (nls or pls variant).
//   Drives d/en toggle patterns into the latch under test and runs a cycle-accurate reference model.
//   Compares the latch output on every clock and reports a mismatch count and the first failing cycle.
//   Sits in 09-ffs next to the latch cells; usable on silicon/FPGA where an initial/$monitor bench is not.
// PARAMETERS
//   D_HALF_PERIOD   6    clock cycles between d_out toggles (>=1)
//   EN_HALF_PERIOD  10   clock cycles between en_out toggles (>=1)
//   RUN_CYCLES      200  length of one run in clock cycles (>=1)
//   EN_ACTIVE_LOW   1    1: latch transparent when en=0 (nls); 0: transparent when en=1 (pls)
//   ERR_W           16   width of error counter
// PORTS
//   clk_in              in   1      single clock
//   rst_n_in            in   1      asynchronous active-low reset
//   start_in            in   1      1-cycle pulse; begins a run from IDLE or DONE
//   q_in                in   1      output of latch under test
//   d_out               out  1      data to latch under test
//   en_out              out  1      enable to latch under test
//   busy_out            out  1      high while in RUN
//   done_out            out  1      high while in DONE
//   pass_out            out  1      valid in DONE: 1 iff err_count_out==0
//   err_count_out       out  ERR_W  mismatches in current/last run, saturating
//   first_err_cyc_out   out  $clog2(RUN_CYCLES+1)  run cycle index of first mismatch; all-ones if none
// BEHAVIOUR
//   - Reset (async, any state incl. mid-run): state=IDLE; d_out=0, en_out=0, busy/done/pass=0,
//     err_count=0, first_err_cyc=all-ones, model q_exp=0, q_valid=0, all counters 0.
//   - FSM: IDLE -start-> RUN; RUN -(cyc==RUN_CYCLES-1)-> DONE; DONE -start-> RUN; else hold.
//     start_in while in RUN is ignored.
//   - Entry to RUN (from IDLE or DONE) clears err_count, first_err_cyc, d/en counters, cyc=0, d_out=0, en_out=0,
//     and loads q_exp/q_valid from the en=0, d=0 state.
//   - RUN cycle k (0..RUN_CYCLES-1): d_out/en_out/q_exp are registered and mutually consistent.
//   - At the edge ending cycle k: if q_valid && q_in!=q_exp, err_count+=1 (saturate at all-ones);
//     first_err_cyc=k only if still all-ones.
//   - Toggling: d counter counts 0..D_HALF_PERIOD-1; on wrap, d_out inverts. en behaves the same with EN_HALF_PERIOD.
//     Both may toggle on the same edge (every lcm cycles, e.g. 30); the model uses both new values.
//   - Reference model, evaluated with the next-state d/en: transparent = (en_next == ~EN_ACTIVE_LOW).
//     If transparent: q_exp<=d_next, q_valid<=1; else q_exp holds.
//   - q_valid stays 0 until the first transparent cycle; no compares occur before it.
//   - DONE: d_out and en_out hold their last values. pass_out=(err_count==0); results hold until the next start or reset.
//   - q_in is treated as settled within one cycle (latch is combinational on the d/en registers); no synchronizer.
// STRUCTURE
//   - Package latch_tb_pkg:
//     - state enum {ST_IDLE, ST_RUN, ST_DONE}, 2 bits;
//     - default period constants D_HALF_PERIOD_DEF=6, EN_HALF_PERIOD_DEF=10, RUN_CYCLES_DEF=200.
//   - Sub-module half_period_toggler (param HALF), instanced twice for d_out and en_out.
//     - Inputs: clr, en. Output: tgl, registered, reset 0.
//     - Counter wraps at HALF-1 and inverts tgl on wrap.
//   - Top holds the FSM, cycle counter, reference model, and error/first-error registers.
// TESTING
//   - Default params, ideal nls latch on q_in, start at t0
//     -> busy 200 cycles, then done=1, pass=1, err=0, first_err=all-ones.
//   - q_in = ~q_exp (inverted ideal latch), EN_ACTIVE_LOW=1
//     -> q_valid from cycle 0, err_count=200, first_err_cyc=0, pass=0.
//   - Ideal latch, check cycle 29->30 edge: d and en toggle together; q_exp uses new en/d; err stays 0.
//   - EN_ACTIVE_LOW=0, ideal pls latch -> no compares in cycles 0..9;
//     the first transparent cycle is 10 (en=1, d=1, q_exp=1); ends pass=1.
//   - rst_n_in low at cycle 57 of a run
//     -> all outputs at reset values immediately; start afterwards gives a full clean 200-cycle run.
//   - start_in pulsed during RUN is ignored (run still ends at 200).
//     start_in in DONE clears the results and a new run begins next cycle.

Source files
------------

// File: rtl/latch_tb_pkg.sv
// Shared types and default timing for the D-latch stimulus/checker block.
package latch_tb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int D_HALF_PERIOD_DEF  = 6;
   localparam int EN_HALF_PERIOD_DEF = 10;
   localparam int RUN_CYCLES_DEF     = 200;

endpackage

// File: rtl/half_period_toggler.sv
// Registered square-wave source: inverts its output each time the counter wraps at HALF-1.
module half_period_toggler #(
   parameter int HALF = 6
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic clr_in,
   input  logic en_in,
   output logic tgl_out,
   output logic tgl_nxt_out
);

   localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tgl_q, tgl_d;

   always_comb begin
      cnt_d = cnt_q;
      tgl_d = tgl_q;
      if (clr_in) begin
         cnt_d = '0;
         tgl_d = 1'b0;
      end else if (en_in) begin
         if (cnt_q == CW'(HALF - 1)) begin
            cnt_d = '0;
            tgl_d = ~tgl_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_q <= '0;
         tgl_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tgl_q <= tgl_d;
      end
   end

   assign tgl_out     = tgl_q;
   // The checker's reference model needs the value the output is about to take.
   assign tgl_nxt_out = tgl_d;

endmodule

// File: rtl/latch_stim_checker.sv
// Drives d/en patterns into a D latch, tracks the expected latch output and
// counts mismatches against the real latch output over one run.
module latch_stim_checker
   import latch_tb_pkg::*;
#(
   parameter int D_HALF_PERIOD  = D_HALF_PERIOD_DEF,
   parameter int EN_HALF_PERIOD = EN_HALF_PERIOD_DEF,
   parameter int RUN_CYCLES     = RUN_CYCLES_DEF,
   parameter bit EN_ACTIVE_LOW  = 1'b1,
   parameter int ERR_W          = 16
) (
   input  logic                                clk_in,
   input  logic                                rst_n_in,
   input  logic                                start_in,
   input  logic                                q_in,
   output logic                                d_out,
   output logic                                en_out,
   output logic                                busy_out,
   output logic                                done_out,
   output logic                                pass_out,
   output logic [ERR_W-1:0]                    err_count_out,
   output logic [$clog2(RUN_CYCLES+1)-1:0]     first_err_cyc_out
);

   localparam int         CYC_W      = $clog2(RUN_CYCLES + 1);
   localparam logic       EN_XPARENT = EN_ACTIVE_LOW ? 1'b0 : 1'b1;
   localparam [ERR_W-1:0] ERR_MAX    = '1;
   localparam [CYC_W-1:0] FE_NONE    = '1;

   state_e             state_q, state_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [CYC_W-1:0]   first_q, first_d;
   logic               q_exp_q, q_exp_d;
   logic               q_valid_q, q_valid_d;

   logic               last_cyc;
   logic               start_go;
   logic               tog_en;
   logic               d_nxt, en_nxt;

   assign last_cyc = (cyc_q == CYC_W'(RUN_CYCLES - 1));
   assign start_go = start_in && (state_q != ST_RUN);
   // Freeze the toggles on the final edge so DONE shows the last run values.
   assign tog_en   = (state_q == ST_RUN) && !last_cyc;

   half_period_toggler #(.HALF(D_HALF_PERIOD)) u_d_tgl (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .clr_in      (start_go),
      .en_in       (tog_en),
      .tgl_out     (d_out),
      .tgl_nxt_out (d_nxt)
   );

   half_period_toggler #(.HALF(EN_HALF_PERIOD)) u_en_tgl (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .clr_in      (start_go),
      .en_in       (tog_en),
      .tgl_out     (en_out),
      .tgl_nxt_out (en_nxt)
   );

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      err_d     = err_q;
      first_d   = first_q;
      q_exp_d   = q_exp_q;
      q_valid_d = q_valid_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_in) begin
               state_d   = ST_RUN;
               cyc_d     = '0;
               err_d     = '0;
               first_d   = FE_NONE;
               q_exp_d   = 1'b0;
               q_valid_d = (EN_XPARENT == 1'b0);
            end
         end
         ST_RUN: begin
            if (q_valid_q && (q_in != q_exp_q)) begin
               if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
               if (first_q == FE_NONE) first_d = cyc_q;
            end
            if (last_cyc) begin
               state_d = ST_DONE;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
               if (en_nxt == EN_XPARENT) begin
                  q_exp_d   = d_nxt;
                  q_valid_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= ST_IDLE;
         cyc_q     <= '0;
         err_q     <= '0;
         first_q   <= FE_NONE;
         q_exp_q   <= 1'b0;
         q_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         err_q     <= err_d;
         first_q   <= first_d;
         q_exp_q   <= q_exp_d;
         q_valid_q <= q_valid_d;
      end
   end

   assign busy_out          = (state_q == ST_RUN);
   assign done_out          = (state_q == ST_DONE);
   assign pass_out          = (state_q == ST_DONE) && (err_q == '0);
   assign err_count_out     = err_q;
   assign first_err_cyc_out = first_q;

endmodule

// File: tb/tb_latch_stim_checker.sv
// Bench: two checkers (nls and pls) each driving a behavioural latch, optionally inverted.
module tb_latch_stim_checker;

   typedef struct {
      int unit;
      int busy;
      int pass;
      int err;
      int first;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_n = 1'b0, start_p = 1'b0;
   logic        inv_n = 1'b0, inv_p = 1'b0;
   logic        lat_n = 1'b0, lat_p = 1'b0;
   logic        q_n, q_p;
   logic [1:0]  d_w, en_w, busy_w, done_w, pass_w;
   logic [15:0] err_w [2];
   logic [7:0]  fe_w [2];

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   // Ideal latches: nls transparent on en=0, pls transparent on en=1.
   always @(d_w[0] or en_w[0]) if (!en_w[0]) lat_n = d_w[0];
   always @(d_w[1] or en_w[1]) if (en_w[1]) lat_p = d_w[1];
   assign q_n = lat_n ^ inv_n;
   assign q_p = lat_p ^ inv_p;

   latch_stim_checker #(.EN_ACTIVE_LOW(1'b1)) u_nls (
      .clk_in(clk), .rst_n_in(rst_n), .start_in(start_n), .q_in(q_n),
      .d_out(d_w[0]), .en_out(en_w[0]), .busy_out(busy_w[0]), .done_out(done_w[0]),
      .pass_out(pass_w[0]), .err_count_out(err_w[0]), .first_err_cyc_out(fe_w[0])
   );

   latch_stim_checker #(.EN_ACTIVE_LOW(1'b0)) u_pls (
      .clk_in(clk), .rst_n_in(rst_n), .start_in(start_p), .q_in(q_p),
      .d_out(d_w[1]), .en_out(en_w[1]), .busy_out(busy_w[1]), .done_out(done_w[1]),
      .pass_out(pass_w[1]), .err_count_out(err_w[1]), .first_err_cyc_out(fe_w[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Monitor: on each rising done, pop the expected run result and compare.
   int  bc [2];
   logic [1:0] done_prev = 2'b00;
   always @(negedge clk) begin
      if (!rst_n) begin
         bc[0] = 0;
         bc[1] = 0;
         done_prev = 2'b00;
      end else begin
         for (int u = 0; u < 2; u++) begin
            if (busy_w[u]) bc[u]++;
            if (done_w[u] && !done_prev[u]) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("unit", u, e.unit);
                  chk("busy_cycles", bc[u], e.busy);
                  chk("pass", pass_w[u], e.pass);
                  chk("err_count", err_w[u], e.err);
                  chk("first_err_cyc", fe_w[u], e.first);
                  $display("run done: unit %0d busy %0d pass %0d err %0d first %0d",
                           u, bc[u], pass_w[u], err_w[u], fe_w[u]);
               end
               bc[u] = 0;
            end
            done_prev[u] = done_w[u];
         end
      end
   end

   task automatic go(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves the caller #1 after the edge that entered RUN, i.e. in run cycle 0.
   task automatic start_run(input int u);
      @(posedge clk); #1;
      if (u == 0) start_n = 1'b1; else start_p = 1'b1;
      @(posedge clk); #1;
      start_n = 1'b0;
      start_p = 1'b0;
   endtask

   task automatic wait_done(input int u);
      int i = 0;
      while (!done_w[u] && i < 300) begin
         @(posedge clk); #1;
         i++;
      end
      chk("done_timeout", done_w[u], 1);
      @(negedge clk); #1;
   endtask

   task automatic push(input int u, input int p, input int e, input int f);
      exp_t x;
      x.unit = u; x.busy = 200; x.pass = p; x.err = e; x.first = f;
      exp_q.push_back(x);
   endtask

   initial begin
      go(3);
      chk("rst_d", d_w[0], 0);
      chk("rst_en", en_w[0], 0);
      chk("rst_busy", busy_w[0], 0);
      chk("rst_done", done_w[0], 0);
      chk("rst_pass", pass_w[0], 0);
      chk("rst_err", err_w[0], 0);
      chk("rst_first", fe_w[0], 255);
      rst_n = 1'b1;

      // Ideal nls run, with a start pulse during RUN that must be ignored.
      push(0, 1, 0, 255);
      start_run(0);
      go(29);
      chk("c29_d", d_w[0], 0);
      chk("c29_en", en_w[0], 0);
      go(1);
      chk("c30_d", d_w[0], 1);
      chk("c30_en", en_w[0], 1);
      chk("c30_err", err_w[0], 0);
      go(70);
      start_n = 1'b1;
      go(1);
      start_n = 1'b0;
      chk("run_busy_after_start", busy_w[0], 1);
      wait_done(0);
      chk("done_hold_d", d_w[0], 1);
      chk("done_hold_en", en_w[0], 1);

      // Inverted nls latch, restarted from DONE.
      inv_n = 1'b1;
      push(0, 0, 200, 0);
      start_run(0);
      chk("restart_busy", busy_w[0], 1);
      chk("restart_done", done_w[0], 0);
      chk("restart_err", err_w[0], 0);
      chk("restart_first", fe_w[0], 255);
      go(1);
      chk("inv_c1_err", err_w[0], 1);
      chk("inv_c1_first", fe_w[0], 0);
      wait_done(0);

      // Reset in the middle of a run, then a clean run.
      start_run(0);
      go(57);
      chk("c57_err", err_w[0], 57);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_d", d_w[0], 0);
      chk("mid_rst_en", en_w[0], 0);
      chk("mid_rst_busy", busy_w[0], 0);
      chk("mid_rst_done", done_w[0], 0);
      chk("mid_rst_pass", pass_w[0], 0);
      chk("mid_rst_err", err_w[0], 0);
      chk("mid_rst_first", fe_w[0], 255);
      @(posedge clk); #1;
      rst_n = 1'b1;
      inv_n = 1'b0;
      push(0, 1, 0, 255);
      start_run(0);
      wait_done(0);

      // Inverted pls latch: no compares before cycle 10.
      inv_p = 1'b1;
      push(1, 0, 190, 10);
      start_run(1);
      go(10);
      chk("pls_c10_d", d_w[1], 1);
      chk("pls_c10_en", en_w[1], 1);
      chk("pls_c10_err", err_w[1], 0);
      chk("pls_c10_first", fe_w[1], 255);
      go(1);
      chk("pls_c11_err", err_w[1], 1);
      chk("pls_c11_first", fe_w[1], 10);
      wait_done(1);

      // Ideal pls latch.
      inv_p = 1'b0;
      push(1, 1, 0, 255);
      start_run(1);
      wait_done(1);

      go(2);
      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
